// File: rtl/mmio_gpo_pkg.sv
// Shared register indices, pulse-timer state encoding and read-back field positions
// for the MMIO general-purpose output slot.
package mmio_gpo_pkg;

    typedef enum logic [4:0] {
        REG_DATA  = 5'd0,
        REG_SET   = 5'd1,
        REG_CLR   = 5'd2,
        REG_TOG   = 5'd3,
        REG_PLEN  = 5'd4,
        REG_PULSE = 5'd5
    } reg_idx_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pulse_state_e;

    localparam int BUSY_BIT    = 0;
    localparam int MASK_RD_OFS = 8;

endpackage

// File: rtl/gpo_pulse_timer.sv
// One-shot pulse generator: holds mask bits for plen cycles after a trigger, retrigger reloads.
// Latency: mask visible one cycle after trigger; no backpressure, every trigger is accepted.
module gpo_pulse_timer
    import mmio_gpo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_trigger,
    input  logic [WIDTH-1:0] i_mask,
    input  logic [CNT_W-1:0] i_plen,
    output logic [WIDTH-1:0] o_pulse_mask,
    output logic             o_busy
);

    pulse_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mask;

    // A trigger always wins over expiry, so a retrigger on the last cycle keeps old bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else if (i_trigger) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= i_plen;
            r_mask  <= r_mask | i_mask;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_mask <= '0;
                end
                ST_ACTIVE: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_mask  <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_mask  <= '0;
                end
            endcase
        end
    end

    assign o_pulse_mask = r_mask;
    assign o_busy       = (r_state == ST_ACTIVE);

endmodule

// File: rtl/mmio_gpo_pulse.sv
// MMIO GPO slot: DATA/SET/CLR/TOG output register, programmable one-shot pulses, read-back.
// Latency: writes reach o_gpo one cycle later; reads are combinational; no backpressure.
module mmio_gpo_pulse
    import mmio_gpo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cs,
    input  logic             i_write,
    input  logic             i_read,
    input  logic [4:0]       i_addr,
    input  logic [31:0]      i_write_data,
    output logic [31:0]      o_read_data,
    output logic [WIDTH-1:0] o_gpo
);

    // Number of pulse-mask bits that fit in the read word above the offset.
    localparam int MASK_RD_W = (WIDTH < 32 - MASK_RD_OFS) ? WIDTH : (32 - MASK_RD_OFS);

    logic [WIDTH-1:0] r_gpo;
    logic [CNT_W-1:0] r_plen;

    logic             w_wr;
    logic [WIDTH-1:0] w_wmask;
    logic             w_trigger;
    logic [WIDTH-1:0] w_pulse_mask;
    logic             w_busy;
    logic             w_unused;

    assign w_wr      = i_cs & i_write;
    assign w_wmask   = i_write_data[WIDTH-1:0];
    assign w_trigger = w_wr && (i_addr == REG_PULSE) && (r_plen != '0) && (w_wmask != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gpo  <= '0;
            r_plen <= '0;
        end else if (w_wr) begin
            case (i_addr)
                REG_DATA: r_gpo  <= w_wmask;
                REG_SET:  r_gpo  <= r_gpo | w_wmask;
                REG_CLR:  r_gpo  <= r_gpo & ~w_wmask;
                REG_TOG:  r_gpo  <= r_gpo ^ w_wmask;
                REG_PLEN: r_plen <= i_write_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    gpo_pulse_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_trigger    (w_trigger),
        .i_mask       (w_wmask),
        .i_plen       (r_plen),
        .o_pulse_mask (w_pulse_mask),
        .o_busy       (w_busy)
    );

    // Pulse bits override only upward; clearing r_gpo never cuts a running pulse short.
    assign o_gpo = r_gpo | w_pulse_mask;

    always_comb begin
        o_read_data = '0;
        case (i_addr)
            REG_DATA: o_read_data[WIDTH-1:0] = o_gpo;
            REG_PLEN: o_read_data[CNT_W-1:0] = r_plen;
            REG_PULSE: begin
                o_read_data[BUSY_BIT]                 = w_busy;
                o_read_data[MASK_RD_OFS +: MASK_RD_W] = w_pulse_mask[MASK_RD_W-1:0];
            end
            default: ;
        endcase
    end

    // Reads have no side effects; high write bits and high mask bits may be dropped.
    assign w_unused = &{1'b0, i_read, i_write_data, w_pulse_mask};

endmodule
